// File: rtl/preproc_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// =============================================================================
// Package  : preproc_pkg
// Brief    : Shared types, defaults and saturating arithmetic for the
//            preprocessing source framer.
// Revision : 1.0 - initial release
// =============================================================================
package preproc_pkg;

    typedef enum logic [1:0] {
        SRC_ADC   = 2'd0,
        SRC_RAMP  = 2'd1,
        SRC_CONST = 2'd2,
        SRC_ZERO  = 2'd3
    } src_sel_e;

    localparam int c_def_adc_width = 14;
    localparam int c_def_out_width = 16;
    localparam int c_def_cps_width = 4;
    localparam int c_def_cps       = 3;

    // Working width of the saturating subtract; callers sign-extend into it.
    // Any output width up to c_sat_w-1 is handled exactly.
    localparam int c_sat_w = 32;

    // a - b computed one bit wider than the operands, then clamped to a
    // signed out_w-bit range; the clamped value is returned sign-extended.
    function automatic logic signed [c_sat_w-1:0] sat_sub(
        input logic signed [c_sat_w-1:0] a,
        input logic signed [c_sat_w-1:0] b,
        input int unsigned               out_w
    );
        logic signed [c_sat_w:0] w_diff;
        logic signed [c_sat_w:0] w_max;
        logic signed [c_sat_w:0] w_min;
        logic signed [c_sat_w:0] w_res;
        w_diff = {a[c_sat_w-1], a} - {b[c_sat_w-1], b};
        w_max  = $signed((33'd1 << (out_w - 1)) - 33'd1);
        w_min  = -w_max - 33'sd1;
        if (w_diff > w_max) begin
            w_res = w_max;
        end else if (w_diff < w_min) begin
            w_res = w_min;
        end else begin
            w_res = w_diff;
        end
        return w_res[c_sat_w-1:0];
    endfunction

endpackage

`default_nettype wire

// File: rtl/sample_strobe_gen.sv
`timescale 1ns/1ps
`default_nettype none
// =============================================================================
// Module   : sample_strobe_gen
// Brief    : Clocks-per-sample divider producing a single-cycle sample strobe.
// Revision : 1.0 - initial release
// =============================================================================
module sample_strobe_gen
    import preproc_pkg::*;
#(
    parameter int CPS_WIDTH = c_def_cps_width
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable,
    input  logic [CPS_WIDTH-1:0] clks_per_sample,
    output logic                 strobe
);

    logic [CPS_WIDTH-1:0] r_count;
    logic [CPS_WIDTH-1:0] w_last_count;

    // A setting of 0 behaves as 1. Using >= lets a lowered setting fire on
    // the very next cycle instead of wrapping the counter.
    assign w_last_count = (clks_per_sample == '0) ? '0
                                                  : clks_per_sample - CPS_WIDTH'(1);
    assign strobe       = enable && (r_count >= w_last_count);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (!enable || strobe) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + CPS_WIDTH'(1);
        end
    end

endmodule

`default_nettype wire

// File: rtl/preproc_source_framer.sv
`timescale 1ns/1ps
`default_nettype none
// =============================================================================
// Module   : preproc_source_framer
// Brief    : Strobed multi-channel source select, saturating offset removal,
//            single-register valid/ready output and packet framing.
// Revision : 1.0 - initial release
// =============================================================================
module preproc_source_framer
    import preproc_pkg::*;
#(
    parameter int ADC_WIDTH  = c_def_adc_width,
    parameter int OUT_WIDTH  = c_def_out_width,
    parameter int NUM_CH     = 2,
    parameter int CPS_WIDTH  = c_def_cps_width,
    parameter int PKT_WIDTH  = 16,
    parameter int STAT_WIDTH = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          enable,
    input  logic [CPS_WIDTH-1:0]          clks_per_sample,
    input  logic [1:0]                    sel_source,
    input  logic [OUT_WIDTH-1:0]          offset,
    input  logic [ADC_WIDTH-1:0]          test_const,
    input  logic [PKT_WIDTH-1:0]          pkt_len,
    input  logic                          clr_stats,
    input  logic [NUM_CH*ADC_WIDTH-1:0]   adc_data,
    output logic [NUM_CH*OUT_WIDTH-1:0]   out_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          out_last,
    output logic [STAT_WIDTH-1:0]         drop_count,
    output logic                          overflow
);

    logic                        w_strobe;
    logic                        w_accept;
    logic                        w_drop;
    logic                        w_is_last;
    logic [ADC_WIDTH-1:0]        r_ramp;
    logic [PKT_WIDTH-1:0]        r_pkt_idx;
    logic [PKT_WIDTH-1:0]        w_len_m1;
    logic [NUM_CH*OUT_WIDTH-1:0] w_sample;
    src_sel_e                    w_sel;

    assign w_sel = src_sel_e'(sel_source);

    sample_strobe_gen #(
        .CPS_WIDTH(CPS_WIDTH)
    ) u_strobe (
        .clk            (clk),
        .rst_n          (rst_n),
        .enable         (enable),
        .clks_per_sample(clks_per_sample),
        .strobe         (w_strobe)
    );

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        logic signed [ADC_WIDTH-1:0] w_src;

        always_comb begin
            w_src = '0;
            case (w_sel)
                SRC_ADC:   w_src = adc_data[k*ADC_WIDTH +: ADC_WIDTH];
                SRC_RAMP:  w_src = r_ramp + ADC_WIDTH'(k);
                SRC_CONST: w_src = test_const;
                default:   w_src = '0;
            endcase
        end

        assign w_sample[k*OUT_WIDTH +: OUT_WIDTH] =
            OUT_WIDTH'(sat_sub(c_sat_w'(w_src), c_sat_w'($signed(offset)), OUT_WIDTH));
    end

    // >= rather than == so a pkt_len shrunk below the current index closes
    // the packet on the next accepted beat.
    assign w_len_m1  = (pkt_len == '0) ? '0 : pkt_len - PKT_WIDTH'(1);
    assign w_is_last = (r_pkt_idx >= w_len_m1);
    assign w_accept  = w_strobe && (!out_valid || out_ready);
    assign w_drop    = w_strobe && !w_accept;

    // Ramp advances on every strobe, accepted or dropped, and survives enable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ramp <= '0;
        end else if (w_strobe) begin
            r_ramp <= r_ramp + ADC_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pkt_idx <= '0;
        end else if (!enable) begin
            r_pkt_idx <= '0;
        end else if (w_accept) begin
            r_pkt_idx <= w_is_last ? '0 : r_pkt_idx + PKT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
        end else if (w_accept) begin
            out_valid <= 1'b1;
            out_last  <= w_is_last;
            out_data  <= w_sample;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Clear has priority over a coincident drop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_count <= '0;
            overflow   <= 1'b0;
        end else if (clr_stats) begin
            drop_count <= '0;
            overflow   <= 1'b0;
        end else if (w_drop) begin
            if (drop_count != '1) begin
                drop_count <= drop_count + STAT_WIDTH'(1);
            end
            overflow <= 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_preproc_source_framer.sv
`timescale 1ns/1ps
`default_nettype none
// =============================================================================
// Module   : tb_preproc_source_framer
// Brief    : Self-checking bench: vector table, directed corner sequences and
//            randomized run against a behavioural reference model.
// Revision : 1.0 - initial release
// =============================================================================
module tb_preproc_source_framer;
    import preproc_pkg::*;

    localparam int ADC_W    = c_def_adc_width;
    localparam int OUT_W    = 16;
    localparam int NCH      = 2;
    localparam int CPS_W    = c_def_cps_width;
    localparam int PKT_W    = 16;
    localparam int STAT_W   = 16;
    localparam int RAMP_MOD = 1 << ADC_W;

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b0;
    logic                    enable = 1'b0;
    logic [CPS_W-1:0]        clks_per_sample = '0;
    logic [1:0]              sel_source = '0;
    logic [OUT_W-1:0]        offset = '0;
    logic [ADC_W-1:0]        test_const = '0;
    logic [PKT_W-1:0]        pkt_len = '0;
    logic                    clr_stats = 1'b0;
    logic [NCH*ADC_W-1:0]    adc_data = '0;
    logic [NCH*OUT_W-1:0]    out_data;
    logic                    out_valid;
    logic                    out_ready = 1'b0;
    logic                    out_last;
    logic [STAT_W-1:0]       drop_count;
    logic                    overflow;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    preproc_source_framer #(
        .ADC_WIDTH (ADC_W),
        .OUT_WIDTH (OUT_W),
        .NUM_CH    (NCH),
        .CPS_WIDTH (CPS_W),
        .PKT_WIDTH (PKT_W),
        .STAT_WIDTH(STAT_W)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .enable         (enable),
        .clks_per_sample(clks_per_sample),
        .sel_source     (sel_source),
        .offset         (offset),
        .test_const     (test_const),
        .pkt_len        (pkt_len),
        .clr_stats      (clr_stats),
        .adc_data       (adc_data),
        .out_data       (out_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_last       (out_last),
        .drop_count     (drop_count),
        .overflow       (overflow)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int sext(input int v, input int w);
        int m;
        int r;
        m = 1 << w;
        r = v % m;
        if (r < 0) r += m;
        return (r >= m / 2) ? r - m : r;
    endfunction

    function automatic int clamp_out(input int v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    function automatic logic [31:0] pack2(input int a, input int b);
        return {16'(b), 16'(a)};
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_valid"}, 64'(out_valid), 64'd0);
        check({tag, "_data"},  64'(out_data),  64'd0);
        check({tag, "_last"},  64'(out_last),  64'd0);
        check({tag, "_drops"}, 64'(drop_count), 64'd0);
        check({tag, "_ovf"},   64'(overflow),  64'd0);
    endtask

    // ---------------- behavioural reference model ----------------
    int m_cnt, m_ramp, m_idx, m_drops;
    bit m_valid, m_last, m_ovf;
    int m_d[2];

    task automatic model_reset();
        m_cnt = 0; m_ramp = 0; m_idx = 0; m_drops = 0;
        m_valid = 0; m_last = 0; m_ovf = 0;
        m_d[0] = 0; m_d[1] = 0;
    endtask

    task automatic model_step();
        int eff_cps, eff_len, off_i, src;
        bit strobe, accept;
        int nd[2];
        eff_cps = (clks_per_sample == '0) ? 1 : int'(clks_per_sample);
        eff_len = (pkt_len == '0) ? 1 : int'(pkt_len);
        strobe  = enable && (m_cnt >= eff_cps - 1);
        off_i   = sext(int'(offset), OUT_W);
        for (int k = 0; k < NCH; k++) begin
            case (sel_source)
                2'd0:    src = sext(int'(adc_data[k*ADC_W +: ADC_W]), ADC_W);
                2'd1:    src = sext(m_ramp + k, ADC_W);
                2'd2:    src = sext(int'(test_const), ADC_W);
                default: src = 0;
            endcase
            nd[k] = clamp_out(src - off_i);
        end
        accept = strobe && (!m_valid || out_ready);
        if (accept) begin
            m_d     = nd;
            m_last  = (m_idx >= eff_len - 1);
            m_idx   = m_last ? 0 : m_idx + 1;
            m_valid = 1;
        end else if (m_valid && out_ready) begin
            m_valid = 0;
        end
        if (!enable) m_idx = 0;
        if (clr_stats) begin
            m_drops = 0;
            m_ovf   = 0;
        end else if (strobe && !accept) begin
            if (m_drops < 65535) m_drops++;
            m_ovf = 1;
        end
        if (strobe) m_ramp = (m_ramp + 1) % RAMP_MOD;
        m_cnt = (!enable || strobe) ? 0 : m_cnt + 1;
    endtask

    typedef struct {
        logic [1:0] sel;
        int adc0, adc1, off, tc;
        int exp0, exp1;
    } vec_t;

    vec_t vecs[12];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{2'd0, -8192,  8191,  32767,     0, -32768, -24576};
        vecs[1]  = '{2'd0,  8191, -8192, -32768,     0,  32767,  24576};
        vecs[2]  = '{2'd0,     5,    -5,      2,     0,      3,     -7};
        vecs[3]  = '{2'd0,    -1,   100,   -100,     0,     99,    200};
        vecs[4]  = '{2'd2,     0,     0,      0,   100,    100,    100};
        vecs[5]  = '{2'd2,     0,     0,    100, -8192,  -8292,  -8292};
        vecs[6]  = '{2'd3,  1234,  4321,     -7,     0,      7,      7};
        vecs[7]  = '{2'd3,     0,     0, -32768,     0,  32767,  32767};
        vecs[8]  = '{2'd3,     0,     0,      1,     0,     -1,     -1};
        vecs[9]  = '{2'd2,     0,     0, -24576,  8191,  32767,  32767};
        vecs[10] = '{2'd2,     0,     0, -24577,  8191,  32767,  32767};
        vecs[11] = '{2'd2,     0,     0,  24576, -8192, -32768, -32768};

        // Reset state
        repeat (3) cyc();
        check_all_zero("reset");
        rst_n = 1'b1;

        // Vector table: strobe every clock, one-beat packets
        enable = 1'b1; clks_per_sample = '0; pkt_len = 16'd1; out_ready = 1'b1;
        foreach (vecs[i]) begin
            sel_source = vecs[i].sel;
            adc_data   = {14'(vecs[i].adc1), 14'(vecs[i].adc0)};
            offset     = 16'(vecs[i].off);
            test_const = 14'(vecs[i].tc);
            cyc();
            check($sformatf("vec%0d_valid", i), 64'(out_valid), 64'd1);
            check($sformatf("vec%0d_data", i), 64'(out_data), 64'(pack2(vecs[i].exp0, vecs[i].exp1)));
            check($sformatf("vec%0d_last", i), 64'(out_last), 64'd1);
        end

        // Divider and latency
        enable = 1'b0; clks_per_sample = 4'(c_def_cps); sel_source = SRC_CONST;
        test_const = 14'd100; offset = '0; pkt_len = 16'd4;
        cyc(); cyc();
        check("div_idle_valid", 64'(out_valid), 64'd0);
        enable = 1'b1;
        begin
            int beat;
            beat = 0;
            for (int j = 1; j <= 24; j++) begin
                cyc();
                check("div_valid", 64'(out_valid), 64'((j % c_def_cps) == 0));
                if ((j % c_def_cps) == 0) begin
                    check("div_data", 64'(out_data), 64'(pack2(100, 100)));
                    check("div_last", 64'(out_last), 64'((beat % 4) == 3));
                    beat++;
                end
            end
        end

        // Back-pressure: first beat held, following strobes dropped
        enable = 1'b0; out_ready = 1'b1; clr_stats = 1'b1; clks_per_sample = 4'd1;
        pkt_len = 16'd3; sel_source = SRC_CONST;
        cyc();
        clr_stats = 1'b0;
        cyc();
        check("bp_idle_valid", 64'(out_valid), 64'd0);
        check("bp_idle_drops", 64'(drop_count), 64'd0);
        enable = 1'b1; out_ready = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            test_const = 14'(1000 + i);
            cyc();
            check("bp_valid", 64'(out_valid), 64'd1);
            check("bp_hold_data", 64'(out_data), 64'(pack2(1001, 1001)));
            check("bp_last", 64'(out_last), 64'd0);
            check("bp_drops", 64'(drop_count), 64'(i - 1));
            check("bp_ovf", 64'(overflow), 64'(i > 1));
        end
        out_ready = 1'b1;
        for (int i = 11; i <= 13; i++) begin
            test_const = 14'(1000 + i);
            cyc();
            check("bp_rel_data", 64'(out_data), 64'(pack2(1000 + i, 1000 + i)));
            check("bp_rel_last", 64'(out_last), 64'(i == 12));
        end

        // Clear coincident with a drop, then a fresh drop
        out_ready = 1'b0; clr_stats = 1'b1;
        cyc();
        check("clr_drops", 64'(drop_count), 64'd0);
        check("clr_ovf", 64'(overflow), 64'd0);
        clr_stats = 1'b0;
        cyc();
        check("clr_next_drops", 64'(drop_count), 64'd1);
        check("clr_next_ovf", 64'(overflow), 64'd1);

        // Enable removed mid-packet
        enable = 1'b0; out_ready = 1'b1; clr_stats = 1'b1; pkt_len = 16'd5; test_const = 14'd7;
        cyc();
        clr_stats = 1'b0;
        cyc();
        check("en_idle_valid", 64'(out_valid), 64'd0);
        enable = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            check("en_pre_valid", 64'(out_valid), 64'd1);
            check("en_pre_last", 64'(out_last), 64'd0);
        end
        enable = 1'b0; out_ready = 1'b0;
        cyc();
        check("en_held_valid", 64'(out_valid), 64'd1);
        check("en_held_last", 64'(out_last), 64'd0);
        out_ready = 1'b1;
        cyc();
        check("en_drained", 64'(out_valid), 64'd0);
        enable = 1'b1;
        for (int b = 0; b < 6; b++) begin
            cyc();
            check("en_re_valid", 64'(out_valid), 64'd1);
            check("en_re_data", 64'(out_data), 64'(pack2(7, 7)));
            check("en_re_last", 64'(out_last), 64'(b == 4));
        end

        // Asynchronous reset in the middle of a stalled stream
        out_ready = 1'b0;
        cyc(); cyc();
        check("prerst_drops", 64'(drop_count), 64'd2);
        check("prerst_valid", 64'(out_valid), 64'd1);
        #3;
        rst_n = 1'b0;
        #1;
        check_all_zero("async_rst");
        enable = 1'b0;
        cyc();

        // Ramp across a full wrap
        rst_n = 1'b1; enable = 1'b1; clks_per_sample = '0; sel_source = SRC_RAMP;
        offset = '0; out_ready = 1'b1; pkt_len = 16'd1;
        for (int j = 1; j <= RAMP_MOD + 6; j++) begin
            cyc();
            check("ramp_valid", 64'(out_valid), 64'd1);
            check("ramp_data", 64'(out_data),
                  64'(pack2(sext((j - 1) % RAMP_MOD, ADC_W), sext(j % RAMP_MOD, ADC_W))));
        end

        // Randomized run against the reference model
        rst_n = 1'b0; enable = 1'b0; clr_stats = 1'b0;
        cyc();
        rst_n = 1'b1;
        model_reset();
        for (int t = 0; t < 4000; t++) begin
            if (t % 37 == 0) clks_per_sample = 4'($urandom_range(0, 4));
            if (t % 23 == 0) pkt_len = 16'($urandom_range(0, 5));
            if (t % 29 == 0) sel_source = 2'($urandom_range(0, 3));
            if (t % 31 == 0) begin
                if ($urandom_range(0, 3) == 0) offset = 16'($urandom);
                else offset = 16'(int'($urandom_range(0, 200)) - 100);
                test_const = 14'($urandom);
            end
            enable    = ($urandom_range(0, 19) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            clr_stats = ($urandom_range(0, 49) == 0);
            adc_data  = 28'($urandom);
            model_step();
            cyc();
            check("rnd_valid", 64'(out_valid), 64'(m_valid));
            if (m_valid) begin
                check("rnd_data", 64'(out_data), 64'(pack2(m_d[0], m_d[1])));
                check("rnd_last", 64'(out_last), 64'(m_last));
            end
            check("rnd_drops", 64'(drop_count), 64'(m_drops));
            check("rnd_ovf", 64'(overflow), 64'(m_ovf));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
